// File: rtl/core_pkg.sv
// Shared core definitions: default pipeline shape, stage names and the perf-counter bundle.
package core_pkg;

  localparam int NSTAGE_DEF = 5;
  localparam int RSTAGE_DEF = 2;
  localparam int CNTW_DEF   = 32;

  typedef enum logic [2:0] {
    S_IF,
    S_ID,
    S_EX,
    S_MEM,
    S_WB
  } stage_e;

  typedef struct packed {
    logic [CNTW_DEF-1:0] cycle;
    logic [CNTW_DEF-1:0] retire;
    logic [CNTW_DEF-1:0] stall;
    logic [CNTW_DEF-1:0] flush;
  } perf_cnt_t;

endpackage

// File: rtl/pipe_perf_cnt.sv
// Four free-running performance counters, each wrapping at the width of its struct field.
// Registered outputs; increments are sampled on the rising edge, no backpressure.
module pipe_perf_cnt
  import core_pkg::*;
#(
  parameter type cnt_t = perf_cnt_t
) (
  input  logic clk,
  input  logic rst,
  input  logic inc_retire,
  input  logic inc_stall,
  input  logic inc_flush,
  output cnt_t cnt
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else begin
      cnt.cycle <= cnt.cycle + 1'b1;
      if (inc_retire) cnt.retire <= cnt.retire + 1'b1;
      if (inc_stall)  cnt.stall  <= cnt.stall + 1'b1;
      if (inc_flush)  cnt.flush  <= cnt.flush + 1'b1;
    end
  end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline sequencer: fetch PC, per-stage enables/clears/valids, latched redirects, perf counters.
// Enables/clears are combinational; PC, valids and counters update one cycle later; busy stages hold upstream.
module pipe_ctrl
  import core_pkg::*;
#(
  parameter int              NSTAGE   = NSTAGE_DEF,
  parameter int              RSTAGE   = RSTAGE_DEF,
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int              CNTW     = CNTW_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NSTAGE-1:0] stage_fin,
  input  logic              lwstall,
  input  logic              redirect,
  input  logic [XLEN-1:0]   redirect_pc,
  input  logic              pred_taken,
  input  logic [XLEN-1:0]   pred_pc,
  output logic [XLEN-1:0]   pc,
  output logic [NSTAGE-1:0] stage_en,
  output logic [NSTAGE-1:0] stage_clr,
  output logic [NSTAGE-1:0] stage_valid,
  output logic [CNTW-1:0]   cnt_cycle,
  output logic [CNTW-1:0]   cnt_retire,
  output logic [CNTW-1:0]   cnt_stall,
  output logic [CNTW-1:0]   cnt_flush
);

  typedef struct packed {
    logic [CNTW-1:0] cycle;
    logic [CNTW-1:0] retire;
    logic [CNTW-1:0] stall;
    logic [CNTW-1:0] flush;
  } cnt_t;

  logic [NSTAGE-1:0] fin;
  logic [NSTAGE-1:0] rdy;
  logic              lw;
  logic              pend_q;
  logic [XLEN-1:0]   tgt_q;
  logic              redir;
  logic              accept;
  logic              unused_fin;
  cnt_t              cnt;

  // Inputs read as zero while reset is held so enables stay low.
  assign fin        = rst ? '0 : stage_fin;
  assign lw         = lwstall & ~rst;
  assign redir      = (redirect & ~rst) | pend_q;
  assign accept     = redir & rdy[RSTAGE+1];
  assign unused_fin = fin[0] ^ fin[NSTAGE-1];

  for (genvar k = 0; k < NSTAGE; k++) begin : g_stage
    localparam int LO = (k > 2) ? k - 1 : 1;
    assign rdy[k] = &fin[NSTAGE-2:LO];

    if (k == 0) begin : g_fetch
      assign stage_en[k]    = rdy[k] & ~lw & ~redir;
      assign stage_clr[k]   = rst;
      assign stage_valid[k] = 1'b1;
    end else begin : g_pipe
      logic v_q;

      if (k <= RSTAGE) begin : g_front
        assign stage_en[k] = rdy[k] & ~lw & ~redir;
      end else begin : g_back
        assign stage_en[k] = rdy[k];
      end

      // The load-use bubble lands in the resolve stage; a redirect wipes everything up to it.
      assign stage_clr[k] = rst
                          | ((k <= RSTAGE) ? accept : 1'b0)
                          | ((k == RSTAGE) ? (lw & rdy[RSTAGE+1]) : 1'b0);

      always_ff @(posedge clk or posedge rst) begin
        if (rst)               v_q <= 1'b0;
        else if (stage_clr[k]) v_q <= 1'b0;
        else if (stage_en[k])  v_q <= stage_valid[k-1];
      end

      assign stage_valid[k] = v_q;
    end
  end

  // A redirect that cannot be taken yet is parked in pend_q/tgt_q; a newer pulse overwrites it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc     <= RESET_PC;
      pend_q <= 1'b0;
      tgt_q  <= '0;
    end else if (accept) begin
      pc     <= redirect ? redirect_pc : tgt_q;
      pend_q <= 1'b0;
    end else begin
      if (redirect) begin
        pend_q <= 1'b1;
        tgt_q  <= redirect_pc;
      end
      if (stage_en[0]) pc <= (pred_taken ? pred_pc : pc) + XLEN'(4);
    end
  end

  pipe_perf_cnt #(
    .cnt_t (cnt_t)
  ) u_perf (
    .clk        (clk),
    .rst        (rst),
    .inc_retire (stage_valid[NSTAGE-1] & stage_en[NSTAGE-1]),
    .inc_stall  (~stage_en[0] & ~redir),
    .inc_flush  (accept),
    .cnt        (cnt)
  );

  assign cnt_cycle  = cnt.cycle;
  assign cnt_retire = cnt.retire;
  assign cnt_stall  = cnt.stall;
  assign cnt_flush  = cnt.flush;

endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Parametrised pipeline sequencer for the in-order core. It owns the fetch PC, per-stage advance enables, bubble/flush clears and per-stage valid bits. It also keeps performance counters. It generalises the core's hard-wired 5-stage stall/flush equations to NSTAGE stages with a configurable resolve stage, and latches redirects so the resolving stage may pulse them for a single cycle. It sits in the core top between the stage modules and the hazard unit.

## Interface
- NSTAGE, 5: pipeline depth; stage 0 = fetch, NSTAGE-1 = writeback; legal 4..8.
- RSTAGE, 2: stage that resolves branches/jumps and receives load-use bubbles; 1 < RSTAGE < NSTAGE-1.
- XLEN, 32: PC width.
- RESET_PC, 0: PC after reset.
- CNTW, 32: counter width.

Ports:
- clk  in  1  clock; all state updates on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- stage_fin  in  NSTAGE  stage k done this cycle; only bits 1..NSTAGE-2 are used.
- lwstall  in  1  load-use hazard from hazard_unit.
- redirect  in  1  single-cycle pulse from RSTAGE on a mispredicted branch/jump.
- redirect_pc  in  XLEN  corrected target, valid with redirect.
- pred_taken  in  1  fetch-side static jump taken (jal).
- pred_pc  in  XLEN  fetch-side target, valid with pred_taken.
- pc  out  XLEN  address to fetch this cycle.
- stage_en  out  NSTAGE  load enable for pipeline register feeding stage k (bit 0 = pc register).
- stage_clr  out  NSTAGE  synchronous clear for that register; clear takes priority over enable.
- stage_valid  out  NSTAGE  stage k holds a real instruction.
- cnt_cycle, cnt_retire, cnt_stall, cnt_flush  out  CNTW each  performance counters.

## Operation
- Downstream readiness: rdy[k] = AND of stage_fin[j] for j = max(k-1,1) .. NSTAGE-2.
- Redirect: pend_q is set by redirect, and tgt_q captures redirect_pc. Effective redirect is redir = redirect | pend_q. A second redirect pulse while pend_q is set overwrites tgt_q.
- Enables:
  - For k ≤ RSTAGE: stage_en[k] = rdy[k] & ~lwstall & ~redir.
  - For k > RSTAGE: stage_en[k] = rdy[k].
- Clears:
  - stage_clr[k] = redir & rdy[RSTAGE+1] for 1 ≤ k ≤ RSTAGE.
  - Additionally, stage_clr[RSTAGE] = lwstall & rdy[RSTAGE+1]; this inserts the bubble.
- Redirect acceptance: a redirect is accepted in a cycle where redir & rdy[RSTAGE+1]. In that cycle:
  - pc ← target (redirect_pc if redirect is high, else tgt_q);
  - pend_q ← 0.
  - If rdy[RSTAGE+1] is low, pend_q holds and the pc holds.
- PC update when stage_en[0]: pc ← (pred_taken ? pred_pc : pc) + 4, computed modulo 2^XLEN. Otherwise pc holds.
- Priority: redirect > lwstall > downstream busy.
- Valid bits:
  - stage_valid[0] = 1 out of reset.
  - stage_valid[k] ← 0 on clear.
  - Otherwise stage_valid[k] ← stage_valid[k-1] on enable.
  - Otherwise it holds.
- Counters (all wrap at 2^CNTW):
  - cnt_cycle +1 every cycle.
  - cnt_retire +1 when stage_valid[NSTAGE-1] & stage_en[NSTAGE-1] (counted on write into the last stage).
  - cnt_stall +1 when ~stage_en[0] & ~redir.
  - cnt_flush +1 per accepted redirect.

## Timing
- Reset (asynchronous, applies immediately):
  - pc = RESET_PC;
  - pend_q = 0;
  - stage_valid = 1 in bit 0, 0 elsewhere;
  - all counters 0.
- stage_en and stage_clr are combinational and low only through their inputs. During reset all inputs are treated as 0 except that clears are forced high for every stage.
- Redirect latency: a redirect in cycle t with RSTAGE+1 ready gives pc = target at t+1, and stages 1..RSTAGE are invalid at t+1.
- If RSTAGE+1 is busy for n cycles, the redirect is applied at t+n+1.
- redirect and lwstall in the same cycle: the redirect wins. The bubble is subsumed by the flush, and the stall counter does not count.
- Reset deasserting mid-redirect: the pending redirect is lost, which is intended.

## Structure
- Shared core package (core_pkg): NSTAGE/RSTAGE defaults; a stage-index enum (S_IF, S_ID, S_EX, S_MEM, S_WB); a perf-counter struct bundling the four counters.
- One sub-module, pipe_perf_cnt: the four counters with wrap, instantiated once.
- The controller is one generate loop over k plus the pc/pend_q registers.

## Test plan
- Reset then idle with stage_fin all 1, NSTAGE=5 → pc 0,4,8,12 on successive cycles; stage_valid fills to 5'b11111 after 4 cycles; cnt_retire increments from cycle 5.
- lwstall for 1 cycle at pc=0x10 → pc holds 0x10 one cycle; stage_clr[2]=1; cnt_stall=1; a bubble (valid 0) reaches stage 4 three cycles later.
- redirect pulse with redirect_pc=0x100 while stage 3 fin=0 for 3 cycles → pc frozen; pc=0x100 the cycle after fin returns; stages 1..2 cleared once; cnt_flush=1.
- redirect + lwstall same cycle, redirect_pc=0x40 → pc=0x40 next cycle; cnt_stall unchanged.
- pred_taken with pred_pc=0x200 → next pc=0x204; pc=0xFFFFFFFC with no prediction → pc wraps to 0.
- rst asserted mid-stall with pend_q set → pc=RESET_PC immediately, pend_q=0, counters 0; repeat with NSTAGE=7, RSTAGE=3 to confirm clears reach bits 1..3.
